ps2_key_rx: RTL and testbench

PS2_KEY_RX -- requirements
Module: ps2_key_rx

---
 rtl/ps2_key_rx.sv | 260 ++++++++++++++++++++++++++
 tb/tb_ps2_key_rx.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver: synchronizes and filters the raw PS/2 lines,
// deframes 11-bit frames, folds E0/F0 prefixes into flags on the following
// scan code and queues decoded keys in a first-word-fall-through FIFO.
module ps2_key_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            ps2_clk,
  input  logic                            ps2_data,
  output logic [7:0]                      key_code,
  output logic                            key_ext,
  output logic                            key_break,
  output logic                            key_valid,
  input  logic                            key_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic                            parity_err,
  output logic                            frame_err,
  output logic                            overflow
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]       FILT_LAST = 8'(FILTER_LEN - 1);
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  // Synchronizer and glitch filter state
  logic       clk_meta_q, clk_sync_q, data_meta_q, data_sync_q;
  logic       filt_q, filt_d, filt_prev_q;
  logic [7:0] filt_cnt_q, filt_cnt_d;
  logic       strobe;

  // Deframer state
  state_e           state_q, state_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic             parity_q, parity_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             byte_done_q, byte_done_d;
  logic [7:0]       byte_q, byte_d;
  logic             frame_err_q, frame_err_d;
  logic             parity_err_q, parity_err_d;

  // Prefix decoder state
  logic       ext_q, ext_d, brk_q, brk_d;
  logic       push;

  // FIFO state
  logic [9:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pop, full, wr_en;
  logic [9:0]       head;

  // Two-flop synchronizers; both idle-high like the PS/2 bus
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
    end else begin
      clk_meta_q  <= ps2_clk;
      clk_sync_q  <= clk_meta_q;
      data_meta_q <= ps2_data;
      data_sync_q <= data_meta_q;
    end
  end

  // Filtered clock flips only after FILTER_LEN samples at the opposite level
  always_comb begin
    filt_d     = filt_q;
    filt_cnt_d = '0;
    if (clk_sync_q != filt_q) begin
      if (filt_cnt_q == FILT_LAST) begin
        filt_d = clk_sync_q;
      end else begin
        filt_cnt_d = filt_cnt_q + 8'd1;
      end
    end
  end

  // Filter registers plus the delayed copy used for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
      filt_cnt_q  <= '0;
    end else begin
      filt_q      <= filt_d;
      filt_prev_q <= filt_q;
      filt_cnt_q  <= filt_cnt_d;
    end
  end

  assign strobe = filt_prev_q & ~filt_q;

  // Frame FSM: shifts bits on each strobe, checks the frame at the stop bit
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    parity_d     = parity_q;
    timer_d      = '0;
    byte_done_d  = 1'b0;
    byte_d       = byte_q;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    if (state_q == S_IDLE) begin
      if (strobe && !data_sync_q) begin
        state_d   = S_DATA;
        shift_d   = '0;
        bit_cnt_d = '0;
      end
    end else if (!strobe && timer_q == TMR_LAST) begin
      frame_err_d = 1'b1;
      state_d     = S_IDLE;
      shift_d     = '0;
      bit_cnt_d   = '0;
      parity_d    = 1'b0;
    end else if (!strobe) begin
      timer_d = timer_q + TMR_W'(1);
    end else begin
      case (state_q)
        S_DATA: begin
          shift_d   = {data_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = S_PARITY;
        end
        S_PARITY: begin
          parity_d = data_sync_q;
          state_d  = S_STOP;
        end
        S_STOP: begin
          state_d = S_IDLE;
          if (!data_sync_q) begin
            frame_err_d = 1'b1;
          end else if (!(^{shift_q, parity_q})) begin
            parity_err_d = 1'b1;
          end else begin
            byte_done_d = 1'b1;
            byte_d      = shift_q;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Frame FSM registers and the registered per-frame results
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      parity_q     <= 1'b0;
      timer_q      <= '0;
      byte_done_q  <= 1'b0;
      byte_q       <= '0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      parity_q     <= parity_d;
      timer_q      <= timer_d;
      byte_done_q  <= byte_done_d;
      byte_q       <= byte_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
    end
  end

  // Prefix decoder: E0/F0 only arm flags, any other byte is pushed with them
  always_comb begin
    ext_d = ext_q;
    brk_d = brk_q;
    push  = 1'b0;
    if (frame_err_q || parity_err_q) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (byte_done_q) begin
      if (byte_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (byte_q == 8'hF0) begin
        brk_d = 1'b1;
      end else begin
        push  = 1'b1;
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end
  end

  // Prefix flag registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ext_q <= 1'b0;
      brk_q <= 1'b0;
    end else begin
      ext_q <= ext_d;
      brk_q <= brk_d;
    end
  end

  assign pop   = (count_q != '0) && key_ready;
  assign full  = (count_q == CNT_FULL);
  assign wr_en = push && (!full || pop);

  // FIFO pointer and occupancy update; pointers wrap naturally at power-of-two depth
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)   rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(wr_en) - CNT_W'(pop);
  end

  // FIFO control registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage; contents are masked at the outputs while empty, so no reset
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {ext_q, brk_q, byte_q};
  end

  assign head       = mem_q[rd_ptr_q];
  assign key_valid  = (count_q != '0);
  assign key_code   = key_valid ? head[7:0] : 8'h00;
  assign key_break  = key_valid & head[8];
  assign key_ext    = key_valid & head[9];
  assign fifo_count = count_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overflow   = push & full & ~pop;

endmodule

// File: tb/tb_ps2_key_rx.sv
// Directed self-checking bench for ps2_key_rx with a short filter,
// short timeout and a 4-entry FIFO.
module tb_ps2_key_rx;

  localparam int FL    = 4;
  localparam int TMO   = 100;
  localparam int DEPTH = 4;
  localparam int HI    = 10;
  localparam int LO    = 10;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       key_ready = 1'b0;
  logic [7:0] key_code;
  logic       key_ext, key_break, key_valid;
  logic [2:0] fifo_count;
  logic       parity_err, frame_err, overflow;

  int checks = 0;
  int errors = 0;
  int perr_seen = 0;
  int ferr_seen = 0;
  int ovf_seen = 0;

  ps2_key_rx #(
    .FILTER_LEN    (FL),
    .TIMEOUT_CYCLES(TMO),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .key_code  (key_code),
    .key_ext   (key_ext),
    .key_break (key_break),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .fifo_count(fifo_count),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .overflow  (overflow)
  );

  // Free-running system clock
  always #5 clk = ~clk;

  // Running tally of every error/overflow pulse seen at a clock edge
  always @(posedge clk) begin
    if (parity_err === 1'b1) perr_seen++;
    if (frame_err === 1'b1) ferr_seen++;
    if (overflow === 1'b1) ovf_seen++;
  end

  // Hard time limit so the run always ends
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic good_par);
    logic p;
    p = good_par ? ~(^b) : (^b);
    return {1'b1, p, b, 1'b0};
  endfunction

  // Drives the first n bits of a frame, one full PS/2 clock period per bit
  task automatic apply_stimulus(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = f[i];
      tick(HI);
      ps2_clk = 1'b0;
      tick(LO);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    apply_stimulus(mk_frame(b, 1'b1), 11);
    tick(HI);
  endtask

  // Drops ps2_clk for the stop bit and lands on the cycle after the strobe
  task automatic stop_begin(input logic stop_val);
    ps2_data = stop_val;
    tick(HI);
    ps2_clk = 1'b0;
    tick(FL + 3);
  endtask

  task automatic stop_end();
    tick(LO - FL - 4);
    ps2_clk = 1'b1;
    tick(HI);
  endtask

  task automatic pop_one();
    key_ready = 1'b1;
    tick(1);
    key_ready = 1'b0;
  endtask

  logic [7:0] exp_codes [4];
  int ferr_before;

  initial begin
    exp_codes[0] = 8'h15;
    exp_codes[1] = 8'h1D;
    exp_codes[2] = 8'h24;
    exp_codes[3] = 8'h2D;

    // Reset values while reset_n is held low
    tick(3);
    check_output("rst_valid", 32'(key_valid), 32'd0);
    check_output("rst_count", 32'(fifo_count), 32'd0);
    check_output("rst_code", 32'(key_code), 32'h00);
    check_output("rst_ext_brk", {30'd0, key_ext, key_break}, 32'd0);
    check_output("rst_pulses", {29'd0, parity_err, frame_err, overflow}, 32'd0);
    reset_n = 1'b1;
    tick(5);

    // 0x1C with its correct parity bit of 0, checking the push latency
    apply_stimulus(mk_frame(8'h1C, 1'b1), 10);
    stop_begin(1'b1);
    check_output("lat_n1_valid", 32'(key_valid), 32'd0);
    tick(1);
    check_output("lat_n2_valid", 32'(key_valid), 32'd1);
    check_output("k1c_code", 32'(key_code), 32'h1C);
    check_output("k1c_ext_brk", {30'd0, key_ext, key_break}, 32'd0);
    check_output("k1c_count", 32'(fifo_count), 32'd1);
    stop_end();
    pop_one();
    check_output("k1c_popped", 32'(fifo_count), 32'd0);
    pop_one();
    check_output("pop_empty", 32'(fifo_count), 32'd0);

    // Extended release sequence E0 F0 75 collapses to one entry
    send_byte(8'hE0);
    send_byte(8'hF0);
    check_output("prefix_no_push", 32'(fifo_count), 32'd0);
    send_byte(8'h75);
    check_output("e0f075_count", 32'(fifo_count), 32'd1);
    check_output("e0f075_code", 32'(key_code), 32'h75);
    check_output("e0f075_ext_brk", {30'd0, key_ext, key_break}, 32'd3);
    pop_one();

    // Bad parity after an E0 prefix: error pulse, no push, prefix dropped
    send_byte(8'hE0);
    apply_stimulus(mk_frame(8'h1C, 1'b0), 10);
    stop_begin(1'b1);
    check_output("perr_pulse", 32'(parity_err), 32'd1);
    check_output("perr_no_ferr", 32'(frame_err), 32'd0);
    tick(1);
    check_output("perr_one_cycle", 32'(parity_err), 32'd0);
    check_output("perr_count", 32'(fifo_count), 32'd0);
    stop_end();
    send_byte(8'h1C);
    check_output("after_perr_code", 32'(key_code), 32'h1C);
    check_output("after_perr_ext_brk", {30'd0, key_ext, key_break}, 32'd0);
    pop_one();

    // Truncated frame times out, then a clean frame still decodes
    ferr_before = ferr_seen;
    apply_stimulus(mk_frame(8'h33, 1'b1), 5);
    for (int i = 0; i < TMO + 60; i++) begin
      if (ferr_seen != ferr_before) break;
      tick(1);
    end
    check_output("timeout_ferr", 32'(ferr_seen - ferr_before), 32'd1);
    check_output("timeout_count", 32'(fifo_count), 32'd0);
    tick(20);
    send_byte(8'h29);
    check_output("after_tmo_code", 32'(key_code), 32'h29);
    check_output("after_tmo_count", 32'(fifo_count), 32'd1);
    pop_one();

    // Fill the FIFO, overflow on the fifth key, then drain in order
    send_byte(8'h15);
    send_byte(8'h1D);
    send_byte(8'h24);
    send_byte(8'h2D);
    check_output("full_count", 32'(fifo_count), 32'd4);
    apply_stimulus(mk_frame(8'h2C, 1'b1), 10);
    stop_begin(1'b1);
    check_output("ovf_pulse", 32'(overflow), 32'd1);
    tick(1);
    check_output("ovf_one_cycle", 32'(overflow), 32'd0);
    check_output("ovf_count", 32'(fifo_count), 32'd4);
    stop_end();
    for (int i = 0; i < 4; i++) begin
      check_output($sformatf("drain_%0d", i), 32'(key_code), 32'(exp_codes[i]));
      pop_one();
    end
    check_output("drained_valid", 32'(key_valid), 32'd0);

    // A low glitch one sample short of the filter length must not start a frame
    ps2_data = 1'b0;
    ps2_clk  = 1'b0;
    tick(FL - 1);
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    tick(20);
    check_output("glitch_count", 32'(fifo_count), 32'd0);
    send_byte(8'h1C);
    check_output("glitch_code", 32'(key_code), 32'h1C);
    check_output("glitch_entry", 32'(fifo_count), 32'd1);

    // Reset in the middle of a frame with an entry queued
    apply_stimulus(mk_frame(8'h29, 1'b1), 4);
    reset_n = 1'b0;
    tick(2);
    check_output("midrst_valid", 32'(key_valid), 32'd0);
    check_output("midrst_count", 32'(fifo_count), 32'd0);
    check_output("midrst_code", 32'(key_code), 32'h00);
    check_output("midrst_flags", {27'd0, key_ext, key_break, parity_err, frame_err, overflow}, 32'd0);
    reset_n = 1'b1;
    tick(5);
    send_byte(8'h29);
    check_output("post_rst_code", 32'(key_code), 32'h29);
    check_output("post_rst_count", 32'(fifo_count), 32'd1);
    check_output("post_rst_ext_brk", {30'd0, key_ext, key_break}, 32'd0);

    // Exactly one of each error pulse over the whole run
    check_output("total_perr", 32'(perr_seen), 32'd1);
    check_output("total_ferr", 32'(ferr_seen), 32'd1);
    check_output("total_ovf", 32'(ovf_seen), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
